// File: rtl/uart_tx_fifo.sv
// UART transmitter with a FIFO in front. The frame format is fixed at build time:
// DATA_BITS payload bits (LSB first), optional even/odd parity, 1 or 2 stop bits.
// A full FIFO_DEPTH burst is accepted without stalling. While enable is high, queued words
// go out back to back with no idle gap between frames.
//
// Ports:
//   clk         in   clock, all logic on the rising edge
//   reset       in   synchronous, active-low reset
//   enable      in   1 = frames may start; 0 = finish the current frame, then hold
//   valid       in   host offers a data word
//   in          in   data word [DATA_BITS-1:0], LSB sent first
//   ready       out  FIFO can accept; a word is pushed when valid && ready
//   out         out  serial TX line, idle high, registered
//   busy        out  high while a frame is on the line
//   fifo_count  out  words waiting, not counting the word on the line
module uart_tx_fifo #(
  parameter int unsigned CLOCK_RATE = 24000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              valid,
  input  logic [DATA_BITS-1:0]              in,
  output logic                              ready,
  output logic                              out,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  // Clocks per bit, rounded to nearest.
  localparam int unsigned DIV    = (CLOCK_RATE + BAUD_RATE / 2) / BAUD_RATE;
  localparam int unsigned CntW   = $clog2(DIV);
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wptr_q, rptr_q;
  logic [CountW-1:0]    count_q;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  // ready ignores a same-cycle pop so that it stays a simple function of the count.
  assign ready = reset && (count_q != CountW'(FIFO_DEPTH));
  assign push  = valid && ready;
  assign head  = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= in;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CountW'(1);
        2'b01:   count_q <= count_q - CountW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign fifo_count = count_q;

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [CntW-1:0]      baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 out_q, out_d;
  logic                 busy_q, busy_d;
  logic                 tick;
  logic                 load;
  logic                 have_word;

  assign tick      = (baud_q == '0);
  assign have_word = enable && (count_q != '0);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    load    = 1'b0;

    unique case (state_q)
      StIdle: begin
        load = have_word;
      end
      StStart: begin
        if (tick) begin
          state_d = StData;
          baud_d  = CntW'(DIV - 1);
          bit_d   = '0;
        end else begin
          baud_d = baud_q - CntW'(1);
        end
      end
      StData: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          baud_d  = CntW'(DIV - 1);
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? StParity : StStop;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q - CntW'(1);
        end
      end
      StParity: begin
        if (tick) begin
          state_d = StStop;
          baud_d  = CntW'(DIV - 1);
          bit_d   = '0;
        end else begin
          baud_d = baud_q - CntW'(1);
        end
      end
      StStop: begin
        if (tick) begin
          if (bit_q == 4'(STOP_BITS - 1)) begin
            // Chain straight into the next frame when a word is waiting.
            if (have_word) begin
              load = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            bit_d  = bit_q + 4'd1;
            baud_d = CntW'(DIV - 1);
          end
        end else begin
          baud_d = baud_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (load) begin
      state_d = StStart;
      baud_d  = CntW'(DIV - 1);
      bit_d   = '0;
      shreg_d = head;
      par_d   = (PARITY == 1) ? ^head : ~^head;
    end
  end

  assign pop = load;

  // Line and busy are registered from the current state, so they lag the state by one
  // clock; every bit-time still lasts exactly DIV clocks on the line.
  always_comb begin
    out_d  = 1'b1;
    busy_d = (state_q != StIdle);
    unique case (state_q)
      StIdle:   out_d = 1'b1;
      StStart:  out_d = 1'b0;
      StData:   out_d = shreg_q[0];
      StParity: out_d = par_q;
      StStop:   out_d = 1'b1;
      default:  out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      out_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. Four instances with different frame formats share one
// stimulus stream; each has a frame-level reference model checked every clock, plus
// directed vectors and sequences aimed mostly at the 8N1 instance (u0, FIFO depth 4).
module tb_uart_tx_fifo;

  localparam int unsigned NDUT = 4;
  localparam int unsigned DIV  = 10;

  function automatic int unsigned cfg_db(int unsigned i);
    return (i == 3) ? 9 : 8;
  endfunction
  function automatic int unsigned cfg_par(int unsigned i);
    return (i == 1) ? 1 : ((i == 2) ? 2 : 0);
  endfunction
  function automatic int unsigned cfg_sb(int unsigned i);
    return (i == 3) ? 2 : 1;
  endfunction
  function automatic int unsigned cfg_depth(int unsigned i);
    return (i == 0) ? 4 : 8;
  endfunction

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       valid = 1'b0;
  logic [8:0] data = '0;

  logic [NDUT-1:0] ready_v, out_v, busy_v;
  logic [7:0]      cnt_v [NDUT];

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // Whole frame as a bit string, bit 0 first on the line; unused high bits are 1 (stop).
  function automatic logic [15:0] build_frame(int unsigned w, int unsigned db, int unsigned par);
    logic [15:0] f;
    int unsigned ones;
    f    = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < int'(db); i++) begin
      f[1+i] = w[i];
      ones += w[i];
    end
    if (par == 1) f[1+db] = (ones % 2 == 1);
    if (par == 2) f[1+db] = (ones % 2 == 0);
    return f;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned DB  = cfg_db(g);
    localparam int unsigned PAR = cfg_par(g);
    localparam int unsigned SB  = cfg_sb(g);
    localparam int unsigned DEP = cfg_depth(g);
    localparam int unsigned LEN = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;

    logic [DB-1:0]               din;
    logic [$clog2(DEP+1)-1:0]    cnt;
    logic                        rdy, o, b;

    assign din = data[DB-1:0];

    uart_tx_fifo #(
      .CLOCK_RATE(1000000),
      .BAUD_RATE (100000),
      .DATA_BITS (DB),
      .PARITY    (PAR),
      .STOP_BITS (SB),
      .FIFO_DEPTH(DEP)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .valid     (valid),
      .in        (din),
      .ready     (rdy),
      .out       (o),
      .busy      (b),
      .fifo_count(cnt)
    );

    assign ready_v[g] = rdy;
    assign out_v[g]   = o;
    assign busy_v[g]  = b;
    assign cnt_v[g]   = 8'(cnt);

    // Reference model: a word queue and a frame in flight, tracked by elapsed clocks.
    int unsigned mq[$];
    bit          m_act = 1'b0;
    int unsigned m_pos = 0;
    logic [15:0] m_frame = '1;
    bit          m_out = 1'b1;
    bit          m_busy = 1'b0;
    int unsigned old_sz;
    bit          do_pop;

    always @(posedge clk) begin
      if (!reset) begin
        mq.delete();
        m_act  = 1'b0;
        m_pos  = 0;
        m_out  = 1'b1;
        m_busy = 1'b0;
      end else begin
        m_out  = m_act ? m_frame[m_pos / DIV] : 1'b1;
        m_busy = m_act;
        if (m_act) begin
          m_pos++;
          if (m_pos == LEN * DIV) m_act = 1'b0;
        end
        old_sz = mq.size();
        do_pop = !m_act && enable && (old_sz > 0);
        if (valid && old_sz != DEP) mq.push_back(32'(din));
        if (do_pop) begin
          m_frame = build_frame(mq.pop_front(), DB, PAR);
          m_act   = 1'b1;
          m_pos   = 0;
        end
      end
    end

    always @(negedge clk) begin
      #1;
      check($sformatf("u%0d out", g), 32'(o), 32'(m_out));
      check($sformatf("u%0d busy", g), 32'(b), 32'(m_busy));
      check($sformatf("u%0d fifo_count", g), 32'(cnt), mq.size());
      check($sformatf("u%0d ready", g), 32'(rdy), 32'(reset && (mq.size() != DEP)));
    end
  end

  // Directed code samples and drives at negedge + 2.
  task automatic step(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  function automatic bit all_idle();
    bit r;
    r = (busy_v == '0);
    for (int i = 0; i < int'(NDUT); i++) if (cnt_v[i] != 0) r = 1'b0;
    return r;
  endfunction

  task automatic wait_idle();
    int unsigned n;
    int unsigned quiet;
    n     = 0;
    quiet = 0;
    while (quiet < 3 && n < 3000) begin
      step(1);
      n++;
      quiet = all_idle() ? quiet + 1 : 0;
    end
    check("wait_idle in bound", 32'(n < 3000), 1);
  endtask

  typedef struct {
    int unsigned dut;
    logic [8:0]  word;
    logic [15:0] bits;
    int unsigned nbits;
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] t3w[4];
  logic [9:0] frm;
  int unsigned n;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Expected line bit strings, first-sent bit in position 0.
    vecs[0] = '{0, 9'h055, 16'h02AA, 10};  // 8N1: 0,10101010,1
    vecs[1] = '{1, 9'h007, 16'h060E, 11};  // 8E1: parity 1
    vecs[2] = '{2, 9'h007, 16'h040E, 11};  // 8O1: parity 0
    vecs[3] = '{3, 9'h1A5, 16'h0F4A, 12};  // 9N2: stop bits 1,1
    t3w[0] = 8'h11; t3w[1] = 8'h22; t3w[2] = 8'h33; t3w[3] = 8'h44;

    // Reset state.
    step(3);
    for (int i = 0; i < int'(NDUT); i++) begin
      check($sformatf("reset u%0d out", i), 32'(out_v[i]), 1);
      check($sformatf("reset u%0d busy", i), 32'(busy_v[i]), 0);
      check($sformatf("reset u%0d count", i), 32'(cnt_v[i]), 0);
      check($sformatf("reset u%0d ready", i), 32'(ready_v[i]), 0);
    end
    reset = 1'b1;
    step(1);
    for (int i = 0; i < int'(NDUT); i++)
      check($sformatf("release u%0d ready", i), 32'(ready_v[i]), 1);
    enable = 1'b1;

    // Single frames in each format.
    for (int v = 0; v < 4; v++) begin
      wait_idle();
      valid = 1'b1;
      data  = vecs[v].word;
      step(1);
      valid = 1'b0;
      check($sformatf("vec%0d count after push", v), 32'(cnt_v[vecs[v].dut]), 1);
      step(1);
      check($sformatf("vec%0d out before fall", v), 32'(out_v[vecs[v].dut]), 1);
      step(1);
      for (int k = 0; k < int'(vecs[v].nbits * DIV); k++) begin
        check($sformatf("vec%0d clk%0d out", v, k), 32'(out_v[vecs[v].dut]),
              32'(vecs[v].bits[k / DIV]));
        check($sformatf("vec%0d clk%0d busy", v, k), 32'(busy_v[vecs[v].dut]), 1);
        step(1);
      end
      check($sformatf("vec%0d busy after", v), 32'(busy_v[vecs[v].dut]), 0);
      check($sformatf("vec%0d out after", v), 32'(out_v[vecs[v].dut]), 1);
      check($sformatf("vec%0d count after", v), 32'(cnt_v[vecs[v].dut]), 0);
    end

    // Fill u0 (depth 4) with enable low; the 5th push is dropped.
    wait_idle();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1;
      data  = {1'b0, t3w[i]};
      step(1);
    end
    check("fill count", 32'(cnt_v[0]), 4);
    check("fill ready", 32'(ready_v[0]), 0);
    data = 9'h055;
    step(1);
    valid = 1'b0;
    check("drop count", 32'(cnt_v[0]), 4);
    check("drop busy", 32'(busy_v[0]), 0);
    enable = 1'b1;
    n = 0;
    while (out_v[0] && n < 10) begin
      step(1);
      n++;
    end
    check("burst start latency", n, 2);
    for (int f = 0; f < 4; f++) begin
      frm = {1'b1, t3w[f], 1'b0};
      for (int k = 0; k < 100; k++) begin
        check($sformatf("burst f%0d clk%0d out", f, k), 32'(out_v[0]), 32'(frm[k / DIV]));
        check($sformatf("burst f%0d clk%0d busy", f, k), 32'(busy_v[0]), 1);
        step(1);
      end
    end
    check("burst end busy", 32'(busy_v[0]), 0);

    // Reset 35 clocks into a frame with two words queued.
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1;
      data  = 9'(9'h0A1 + 9'(i * 17));
      step(1);
    end
    valid = 1'b0;
    n = 0;
    while (!busy_v[0] && n < 10) begin
      step(1);
      n++;
    end
    check("rst frame started", 32'(busy_v[0]), 1);
    step(35);
    check("rst queued", 32'(cnt_v[0]), 2);
    reset = 1'b0;
    step(1);
    check("rst out", 32'(out_v[0]), 1);
    check("rst busy", 32'(busy_v[0]), 0);
    check("rst count", 32'(cnt_v[0]), 0);
    check("rst ready low", 32'(ready_v[0]), 0);
    reset = 1'b1;
    step(1);
    check("rst ready after release", 32'(ready_v[0]), 1);
    for (int k = 0; k < 30; k++) begin
      check($sformatf("rst idle clk%0d out", k), 32'(out_v[0]), 1);
      step(1);
    end

    // Drop enable 40 clocks into a frame with one word queued.
    wait_idle();
    for (int i = 0; i < 2; i++) begin
      valid = 1'b1;
      data  = 9'(9'h03C + 9'(i * 65));
      step(1);
    end
    valid = 1'b0;
    n = 0;
    while (!busy_v[0] && n < 10) begin
      step(1);
      n++;
    end
    step(40);
    enable = 1'b0;
    n = 0;
    while (busy_v[0] && n < 200) begin
      step(1);
      n++;
    end
    check("hold frame length", 40 + n, 100);
    for (int k = 0; k < 20; k++) begin
      check($sformatf("hold clk%0d out", k), 32'(out_v[0]), 1);
      check($sformatf("hold clk%0d count", k), 32'(cnt_v[0]), 1);
      step(1);
    end
    enable = 1'b1;
    n = 0;
    while (out_v[0] && n < 10) begin
      step(1);
      n++;
    end
    check("resume latency", n, 2);

    // Random traffic against the models.
    for (int c = 0; c < 4000; c++) begin
      valid = ($urandom % 6 == 0);
      data  = 9'($urandom);
      if (c % 250 == 0) enable = ($urandom % 4 != 0);
      reset = ($urandom % 1200 != 0);
      step(1);
    end
    reset  = 1'b1;
    valid  = 1'b0;
    enable = 1'b1;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
